// File: rtl/pipelined_write_rx.sv
// Receive stage for the pipelined write protocol: assembles command + data cycles into one word.
// Optional IDLE-stall timeout enabled by defining PIPELINED_WRITE_RX_TIMEOUT_EN.

package test_pkg_b;
  localparam logic [2:0] WT_STD          = 3'd0;
  localparam logic [2:0] WT_MULTI_WDONE  = 3'd1;
  localparam logic [2:0] WT_SINGLE_WDONE = 3'd2;

  localparam logic [1:0] CT_IDLE  = 2'd0;
  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;

  typedef struct packed {
    logic       val;
    logic [2:0] write_type;
    logic [1:0] num_cycles;
    logic [3:0] rsvd;
  } write_cmd_t;

  typedef struct packed {
    logic [1:0] cycle_type;
    logic [7:0] dat;
  } write_dat_t;

  typedef struct packed {
    write_cmd_t cmd_cycle;
    write_dat_t dat3;
    write_dat_t dat2;
    write_dat_t dat1;
    write_dat_t dat0;
  } pipelined_write_t;
endpackage

module pipelined_write_rx
  import test_pkg_b::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  in_cyc,
  output logic        in_rdy,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [49:0] out_write,
  output logic [2:0]  out_beats,
  output logic        wdone,
  output logic [3:0]  err
);

  typedef enum logic {S_IDLE, S_DATA} state_e;
  typedef enum logic [1:0] {MODE_STD, MODE_MULTI, MODE_SINGLE} mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  pipelined_write_t work_q, work_d;
  logic [2:0]       k_q, k_d;
  logic [2:0]       n_q, n_d;
  logic [2:0]       k_inc;
  logic             vld_d;
  pipelined_write_t write_d;
  logic [2:0]       beats_d;
  logic             wdone_d;
  logic [3:0]       err_d;
  write_cmd_t       cmd_c;
  write_dat_t       dat_c;

`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`endif

  assign cmd_c  = write_cmd_t'(in_cyc);
  assign dat_c  = write_dat_t'(in_cyc);
  assign in_rdy = (state_q == S_IDLE) && (!out_vld || out_rdy);

  // Next-state, assembly and output-slice logic
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    work_d  = work_q;
    k_d     = k_q;
    n_d     = n_q;
    vld_d   = out_vld && !out_rdy;
    write_d = pipelined_write_t'(out_write);
    beats_d = out_beats;
    wdone_d = 1'b0;
    err_d   = 4'b0000;
    k_inc   = (k_q == 3'd4) ? 3'd4 : k_q + 3'd1;
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cmd_c.val && in_rdy) begin
          work_d           = '0;
          work_d.cmd_cycle = cmd_c;
          k_d              = 3'd0;
          n_d              = (cmd_c.num_cycles == 2'd0) ? 3'd4 : {1'b0, cmd_c.num_cycles};
          state_d          = S_DATA;
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
          tcnt_d           = '0;
`endif
          // Unknown write types raise an error and fall back to plain writes
          unique case (cmd_c.write_type)
            WT_STD:          mode_d = MODE_STD;
            WT_MULTI_WDONE:  mode_d = MODE_MULTI;
            WT_SINGLE_WDONE: mode_d = MODE_SINGLE;
            default: begin
              mode_d   = MODE_STD;
              err_d[2] = 1'b1;
            end
          endcase
        end
      end
      S_DATA: begin
        if (dat_c.cycle_type == CT_VALID || dat_c.cycle_type == CT_DONE) begin
          case (k_q[1:0])
            2'd0: work_d.dat0 = dat_c;
            2'd1: work_d.dat1 = dat_c;
            2'd2: work_d.dat2 = dat_c;
            2'd3: work_d.dat3 = dat_c;
          endcase
          k_d = k_inc;
          if (mode_q == MODE_MULTI) wdone_d = 1'b1;
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
          tcnt_d = '0;
`endif
          if (dat_c.cycle_type == CT_DONE || k_inc == n_q) begin
            err_d[0] = (dat_c.cycle_type == CT_DONE) && (k_inc < n_q);
            err_d[1] = (dat_c.cycle_type == CT_VALID);
            if (mode_q == MODE_SINGLE) wdone_d = 1'b1;
            write_d = work_d;
            beats_d = k_inc;
            vld_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
          // Stall cycle: abandon the write once the allowed stall budget is spent
          if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES)) begin
            err_d[3] = 1'b1;
            state_d  = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_STD;
      work_q    <= '0;
      k_q       <= 3'd0;
      n_q       <= 3'd0;
      out_vld   <= 1'b0;
      out_write <= '0;
      out_beats <= 3'd0;
      wdone     <= 1'b0;
      err       <= 4'b0000;
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
      tcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      work_q    <= work_d;
      k_q       <= k_d;
      n_q       <= n_d;
      out_vld   <= vld_d;
      out_write <= write_d;
      out_beats <= beats_d;
      wdone     <= wdone_d;
      err       <= err_d;
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_write_rx.sv
// Bench for pipelined_write_rx: directed vector table plus randomized traffic vs. a queue-based model.
module tb_pipelined_write_rx;
  import test_pkg_b::*;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst;
  logic [9:0]  in_cyc;
  logic        in_rdy;
  logic        out_vld;
  logic        out_rdy;
  logic [49:0] out_write;
  logic [2:0]  out_beats;
  logic        wdone;
  logic [3:0]  err;

  int total;
  int bad;

  pipelined_write_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_cyc(in_cyc), .in_rdy(in_rdy), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_write(out_write), .out_beats(out_beats),
    .wdone(wdone), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one write in flight, beats collected in a queue
  logic        m_busy;
  write_cmd_t  m_cmd;
  int          m_n;
  int          m_mode;
  write_dat_t  m_q[$];
  int          m_idle;
  logic        m_vld;
  logic [49:0] m_write;
  logic [2:0]  m_beats;
  logic        m_wdone;
  logic [3:0]  m_err;

  typedef struct {
    logic        r;
    logic [9:0]  c;
    logic        ordy;
    logic        xr;
    logic        xv;
    logic [2:0]  xb;
    logic        xw;
    logic [3:0]  xe;
    logic        cw;
    logic [49:0] xwr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] mk_cmd(input logic [2:0] wt, input logic [1:0] nc, input logic [3:0] rs);
    return {1'b1, wt, nc, rs};
  endfunction

  function automatic logic [9:0] mk_dat(input logic [1:0] ct, input logic [7:0] d);
    return {ct, d};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_cmd = '0; m_n = 0; m_mode = 0; m_q.delete(); m_idle = 0;
    m_vld = 1'b0; m_write = '0; m_beats = 3'd0; m_wdone = 1'b0; m_err = 4'b0;
  endtask

  task automatic model_step(input logic r, input logic [9:0] c, input logic ordy);
    write_cmd_t cm;
    write_dat_t dt;
    write_dat_t d[4];
    logic rdy;
    cm = write_cmd_t'(c);
    dt = write_dat_t'(c);
    if (r) begin
      model_reset();
      return;
    end
    rdy = !m_busy && (!m_vld || ordy);
    m_wdone = 1'b0;
    m_err   = 4'b0;
    if (m_vld && ordy) m_vld = 1'b0;
    if (!m_busy) begin
      if (cm.val && rdy) begin
        m_busy = 1'b1;
        m_cmd  = cm;
        m_n    = (cm.num_cycles == 2'd0) ? 4 : int'(cm.num_cycles);
        m_q.delete();
        m_idle = 0;
        if (cm.write_type > 3'd2) begin
          m_err[2] = 1'b1;
          m_mode   = 0;
        end else begin
          m_mode = int'(cm.write_type);
        end
      end
    end else if (dt.cycle_type == CT_VALID || dt.cycle_type == CT_DONE) begin
      m_q.push_back(dt);
      m_idle = 0;
      if (m_mode == 1) m_wdone = 1'b1;
      if (dt.cycle_type == CT_DONE || m_q.size() == m_n) begin
        if (dt.cycle_type == CT_VALID) m_err[1] = 1'b1;
        else if (m_q.size() < m_n) m_err[0] = 1'b1;
        if (m_mode == 2) m_wdone = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = (i < m_q.size()) ? m_q[i] : write_dat_t'(10'd0);
        m_write = {m_cmd, d[3], d[2], d[1], d[0]};
        m_beats = 3'(m_q.size());
        m_vld   = 1'b1;
        m_busy  = 1'b0;
      end
    end else begin
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
      if (m_idle == int'(TO)) begin
        m_err[3] = 1'b1;
        m_busy   = 1'b0;
      end else begin
        m_idle++;
      end
`endif
    end
  endtask

  // One clock: drive, check in_rdy, advance, check registered outputs against the model
  task automatic cyc(input logic r, input logic [9:0] c, input logic ordy, output logic rdy_seen);
    logic exp_rdy;
    rst = r; in_cyc = c; out_rdy = ordy;
    #1;
    rdy_seen = in_rdy;
    exp_rdy  = !m_busy && (!m_vld || ordy);
    if (!r) chk("model_in_rdy", 64'(in_rdy), 64'(exp_rdy));
    model_step(r, c, ordy);
    @(posedge clk);
    #1;
    chk("model_out_vld", 64'(out_vld), 64'(m_vld));
    chk("model_out_write", 64'(out_write), 64'(m_write));
    chk("model_out_beats", 64'(out_beats), 64'(m_beats));
    chk("model_wdone", 64'(wdone), 64'(m_wdone));
    chk("model_err", 64'(err), 64'(m_err));
  endtask

  task automatic add(input logic r, input logic [9:0] c, input logic ordy, input logic xr,
                     input logic xv, input logic [2:0] xb, input logic xw, input logic [3:0] xe,
                     input logic cw, input logic [49:0] xwr);
    vec_t v;
    v.r = r; v.c = c; v.ordy = ordy; v.xr = xr; v.xv = xv; v.xb = xb;
    v.xw = xw; v.xe = xe; v.cw = cw; v.xwr = xwr;
    vecs.push_back(v);
  endtask

  initial begin
    logic [49:0] w1, w2, w3, w4;
    logic        rs;
    logic [9:0]  c;
    logic        ordy;
    int          e3;
    int          vseen;

    total = 0;
    bad   = 0;
    rst = 1'b1; in_cyc = '0; out_rdy = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    w1 = {mk_cmd(3'd0, 2'd2, 4'd5), 10'd0, 10'd0, mk_dat(CT_DONE, 8'hB2), mk_dat(CT_VALID, 8'hA1)};
    w2 = {mk_cmd(3'd1, 2'd0, 4'hA), mk_dat(CT_DONE, 8'h13), mk_dat(CT_VALID, 8'h12),
          mk_dat(CT_VALID, 8'h11), mk_dat(CT_VALID, 8'h10)};
    w3 = {mk_cmd(3'd2, 2'd1, 4'd3), 10'd0, 10'd0, 10'd0, mk_dat(CT_DONE, 8'h55)};
    w4 = {mk_cmd(3'd0, 2'd3, 4'd0), 10'd0, 10'd0, mk_dat(CT_DONE, 8'h02), mk_dat(CT_VALID, 8'h01)};

    // reset state
    add(1, 10'd0, 0, 0, 0, 3'd0, 0, 4'd0, 1, 50'd0);
    add(1, 10'd0, 0, 0, 0, 3'd0, 0, 4'd0, 1, 50'd0);
    // 2-beat STD write with downstream stall
    add(0, mk_cmd(3'd0, 2'd2, 4'd5), 1, 1, 0, 3'd0, 0, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_VALID, 8'hA1), 1, 0, 0, 3'd0, 0, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_DONE, 8'hB2), 0, 0, 1, 3'd2, 0, 4'd0, 1, w1);
    add(0, 10'd0, 0, 0, 1, 3'd2, 0, 4'd0, 1, w1);
    add(0, 10'd0, 1, 1, 0, 3'd2, 0, 4'd0, 0, 50'd0);
    // 4-beat MULTI_WDONE write with stalls (incl. undefined cycle type)
    add(0, mk_cmd(3'd1, 2'd0, 4'hA), 1, 1, 0, 3'd2, 0, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_VALID, 8'h10), 1, 0, 0, 3'd2, 1, 4'd0, 0, 50'd0);
    add(0, 10'd0, 1, 0, 0, 3'd2, 0, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_VALID, 8'h11), 1, 0, 0, 3'd2, 1, 4'd0, 0, 50'd0);
    add(0, mk_dat(2'd3, 8'hEE), 1, 0, 0, 3'd2, 0, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_VALID, 8'h12), 1, 0, 0, 3'd2, 1, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_DONE, 8'h13), 1, 0, 1, 3'd4, 1, 4'd0, 1, w2);
    // SINGLE_WDONE accepted alongside downstream accept, then held 5 cycles
    add(0, mk_cmd(3'd2, 2'd1, 4'd3), 1, 1, 0, 3'd4, 0, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_DONE, 8'h55), 0, 0, 1, 3'd1, 1, 4'd0, 1, w3);
    for (int i = 0; i < 5; i++) add(0, mk_cmd(3'd0, 2'd1, 4'd0), 0, 0, 1, 3'd1, 0, 4'd0, 1, w3);
    add(0, mk_cmd(3'd0, 2'd1, 4'd0), 1, 1, 0, 3'd1, 0, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_DONE, 8'h66), 1, 0, 1, 3'd1, 0, 4'd0, 0, 50'd0);
    // short write then long write
    add(0, mk_cmd(3'd0, 2'd3, 4'd0), 1, 1, 0, 3'd1, 0, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_VALID, 8'h01), 1, 0, 0, 3'd1, 0, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_DONE, 8'h02), 1, 0, 1, 3'd2, 0, 4'b0001, 1, w4);
    add(0, mk_cmd(3'd0, 2'd1, 4'd0), 1, 1, 0, 3'd2, 0, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_VALID, 8'h07), 1, 0, 1, 3'd1, 0, 4'b0010, 0, 50'd0);
    // bad write_type behaves as STD
    add(0, mk_cmd(3'd5, 2'd1, 4'd0), 1, 1, 0, 3'd1, 0, 4'b0100, 0, 50'd0);
    add(0, mk_dat(CT_DONE, 8'h08), 1, 0, 1, 3'd1, 0, 4'd0, 0, 50'd0);
    // reset mid-write, then a clean 1-beat write
    add(0, mk_cmd(3'd1, 2'd0, 4'd0), 1, 1, 0, 3'd1, 0, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_VALID, 8'h21), 1, 0, 0, 3'd1, 1, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_VALID, 8'h22), 1, 0, 0, 3'd1, 1, 4'd0, 0, 50'd0);
    add(1, mk_dat(CT_VALID, 8'h23), 1, 0, 0, 3'd0, 0, 4'd0, 1, 50'd0);
    add(0, mk_cmd(3'd0, 2'd1, 4'd0), 1, 1, 0, 3'd0, 0, 4'd0, 0, 50'd0);
    add(0, mk_dat(CT_DONE, 8'h09), 1, 0, 1, 3'd1, 0, 4'd0, 0, 50'd0);
    add(0, 10'd0, 1, 1, 0, 3'd1, 0, 4'd0, 0, 50'd0);

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].c, vecs[i].ordy, rs);
      if (!vecs[i].r) chk($sformatf("vec%0d_in_rdy", i), 64'(rs), 64'(vecs[i].xr));
      chk($sformatf("vec%0d_out_vld", i), 64'(out_vld), 64'(vecs[i].xv));
      chk($sformatf("vec%0d_out_beats", i), 64'(out_beats), 64'(vecs[i].xb));
      chk($sformatf("vec%0d_wdone", i), 64'(wdone), 64'(vecs[i].xw));
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].xe));
      if (vecs[i].cw) chk($sformatf("vec%0d_out_write", i), 64'(out_write), 64'(vecs[i].xwr));
    end

    // 17 consecutive stall cycles inside a 2-beat write
    cyc(0, mk_cmd(3'd0, 2'd2, 4'd0), 1, rs);
    cyc(0, mk_dat(CT_VALID, 8'h31), 1, rs);
    e3 = 0;
    vseen = 0;
    for (int i = 0; i < 17; i++) begin
      cyc(0, mk_dat(CT_IDLE, 8'h00), 1, rs);
      if (err[3]) e3++;
      if (out_vld) vseen++;
    end
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
    chk("timeout_err3_pulses", 64'(e3), 64'd1);
    chk("timeout_no_vld", 64'(vseen), 64'd0);
    cyc(0, 10'd0, 1, rs);
    chk("timeout_back_to_idle", 64'(rs), 64'd1);
    chk("timeout_still_no_vld", 64'(out_vld), 64'd0);
`else
    chk("stall_no_err3", 64'(e3), 64'd0);
    chk("stall_no_vld", 64'(vseen), 64'd0);
    cyc(0, mk_dat(CT_DONE, 8'h32), 1, rs);
    chk("stall_done_vld", 64'(out_vld), 64'd1);
    chk("stall_done_beats", 64'(out_beats), 64'd2);
    chk("stall_done_err", 64'(err), 64'd0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int sel;
      ordy = ($urandom_range(0, 3) != 0);
      if (m_busy) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 5)      c = mk_dat(CT_VALID, 8'($urandom));
        else if (sel < 7) c = mk_dat(CT_DONE, 8'($urandom));
        else if (sel < 9) c = mk_dat(CT_IDLE, 8'($urandom));
        else              c = mk_dat(2'd3, 8'($urandom));
      end else begin
        c = 10'($urandom);
      end
      cyc(($urandom_range(0, 299) == 0), c, ordy, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_write_rx.md
# pipelined_write_rx

Receive stage for the pipelined write protocol defined in `test_pkg_b`. It consumes the 10-bit serial stream made of one `write_cmd_t` command cycle followed by `write_dat_t` data cycles. It assembles the stream into one `pipelined_write_t` and hands that word downstream through a valid/ready register slice. Per `WRITE_TYPE_E`, it also generates write-done pulses and flags protocol violations.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum consecutive IDLE data cycles allowed inside a write. Used only with the timeout feature.
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `in_cyc`  in  10  current cycle. Read as `write_cmd_t` in IDLE state and as `write_dat_t` in DATA state.
- `in_rdy`  out  1  stage can accept a command cycle
- `out_vld`  out  1  assembled write available
- `out_rdy`  in  1  downstream accepts `out_write`
- `out_write`  out  50  `pipelined_write_t`
- `out_beats`  out  3  number of data beats stored (1..4)
- `wdone`  out  1  write-done pulse
- `err`  out  4  one-cycle error pulses: [0] short, [1] long, [2] bad write_type, [3] timeout

## Operation
- **State IDLE**
  - `in_cyc` is a command when `val=1 && in_rdy`.
  - On a command: capture the whole `write_cmd_t` into `cmd_cycle`, including `rsvd` unchanged.
  - Set N = 4 when `num_cycles==0`, otherwise N = `num_cycles`.
  - Clear the beat count k and the dat0..dat3 slots to 0, then go to DATA.
  - `val=0` cycles are ignored.
- **State DATA**
  - `cycle_type` IDLE: stall. Nothing is stored and k is unchanged.
  - `cycle_type` VALID: store `dat` into slot k, then k++.
    - If k+1 < N, stay in DATA.
    - If k+1 == N (VALID on the final beat), pulse `err[1]` and complete.
  - `cycle_type` DONE: store `dat` into slot k, then k++, and complete.
    - If k+1 < N, pulse `err[0]` (short write).
    - Unfilled slots stay 0.
  - Encoding value 3 (undefined): treated as IDLE, and `err[0]` is not raised.
- **Complete**
  - Load `out_write`, set `out_beats` = k, assert `out_vld`, return to IDLE.
- **write_type handling** (decoded at command capture)
  - STD: no `wdone`.
  - MULTI_WDONE: one `wdone` per stored data beat.
  - SINGLE_WDONE: one `wdone` at completion.
  - Values 3..7: `err[2]` pulses at capture, then behave as STD.
- **Output slice**
  - `out_vld` holds until `out_vld && out_rdy`; `out_write` is stable while `out_vld=1`.
  - `in_rdy = (state==IDLE) && (!out_vld || out_rdy)`. A command is accepted only when the slot will be free.
  - DATA state never backpressures; data cycles are always consumed.
- **Arithmetic**
  - k is 3 bits and saturates at 4 (it cannot exceed N by construction).
  - `out_beats` equals k at completion.

## Timing
- **Reset values**
  - `out_vld=0`, `out_write=0`, `out_beats=0`, `wdone=0`, `err=0`.
  - `in_rdy=1` in the first cycle after reset deasserts.
  - State is IDLE.
- **Latencies**
  - Completion beat at cycle t: `out_vld` and `out_write` are valid at t+1.
  - MULTI `wdone`: t+1 after each stored beat.
  - SINGLE `wdone`: t+1 after completion, coincident with the first `out_vld` cycle.
  - `err[0..1]`: t+1 after the completing beat.
  - `err[2]`: t+1 after command capture.
- **Back-to-back writes**
  - A command may arrive in the cycle right after a completion beat if `out_rdy=1` in that cycle.
  - Best-case throughput is N+1 input cycles per write.
- **Simultaneous events**
  - Downstream accept and completion in the same cycle: cannot occur, since the slot is free on entry to DATA.
  - Accept in the same cycle as a new command: allowed.
- **Reset mid-operation**
  - A partial write is discarded; no `wdone` or `err` is emitted for it.
  - A pending `out_vld` is dropped.

## Configuration
- **`PIPELINED_WRITE_RX_TIMEOUT_EN` defined**
  - A counter of consecutive IDLE cycles in DATA state clears on any VALID or DONE cycle.
  - When the count reaches `TIMEOUT_CYCLES`, the next IDLE cycle pulses `err[3]` (at t+1) and returns to IDLE.
  - The partial write is discarded: no `out_vld` and no completion `wdone`. MULTI `wdone` pulses already issued stand.
- **Not defined**
  - The counter is absent, and DATA stalls indefinitely on IDLE cycles.
  - `err[3]` is tied to 0 and `TIMEOUT_CYCLES` is unused.

## Test plan
- Cmd `num_cycles=2`, STD; data VALID 0xA1, DONE 0xB2 -> `out_vld` one cycle after DONE, with dat0=A1, dat1=B2, dat2=dat3=0, `out_beats=2`. No `wdone`, `err=0`.
- Cmd `num_cycles=0`, MULTI_WDONE; four beats 0x10..0x13 with two IDLE stalls interleaved, last beat DONE -> four `wdone` pulses; `out_beats=4`, dat0..3=0x10..0x13.
- SINGLE_WDONE write completed with `out_rdy=0` held 5 cycles; next cmd presented -> exactly one `wdone` with the first `out_vld` cycle. `in_rdy=0` until `out_rdy=1`, then the cmd is accepted that cycle.
- Short and long writes:
  - `num_cycles=3` with DONE on the 2nd beat -> `err[0]`, `out_beats=2`, dat2=0.
  - `num_cycles=1` with VALID on the 1st beat -> `err[1]`, write emitted with 1 beat.
- `rst` asserted after 2 of 4 beats -> all outputs at reset values next cycle. A following 1-beat STD write completes cleanly with `err=0`.
- Timeout with the macro, `TIMEOUT_CYCLES=16`: 17 consecutive IDLE cycles mid-write -> `err[3]` pulse, no `out_vld`, state IDLE. Without the macro: no error, and the write completes when DONE eventually arrives.
